// File: rtl/reg_file_pkg.sv
// Shared constants and types for the integer register file and its scoreboard.
// The defaults describe the baseline 32 x 32-bit configuration.
package reg_file_pkg;

   localparam int DATA_W_DEF   = 32;
   localparam int NUM_REGS_DEF = 32;
   localparam int ADDR_W_DEF   = $clog2(NUM_REGS_DEF);
   localparam int ZERO_ADDR    = 0;

   typedef logic [ADDR_W_DEF-1:0] reg_addr_t;
   typedef logic [DATA_W_DEF-1:0] reg_data_t;

endpackage

// File: rtl/reg_scoreboard.sv
// Per-register pending bits for the hazard unit, with flush/clear/set ordering
// and a registered population count of the pending vector.
module reg_scoreboard import reg_file_pkg::*; #(
   parameter int NUM_REGS = NUM_REGS_DEF,
   parameter int ADDR_W   = $clog2(NUM_REGS),
   parameter bit ZERO_REG = 1'b1
) (
   input  logic                          i_clk,
   input  logic                          i_rst_n,
   input  logic                          i_flush,
   input  logic                          i_wr0_en,
   input  logic [ADDR_W-1:0]             i_wr0_addr,
   input  logic                          i_wr1_en,
   input  logic [ADDR_W-1:0]             i_wr1_addr,
   input  logic                          i_iss_en,
   input  logic [ADDR_W-1:0]             i_iss_addr,
   output logic [NUM_REGS-1:0]           o_pending,
   output logic [$clog2(NUM_REGS+1)-1:0] o_pend_cnt
);

   localparam int CNT_W = $clog2(NUM_REGS + 1);

   logic [NUM_REGS-1:0] pend_r;
   logic [NUM_REGS-1:0] pend_nxt_s;
   logic [CNT_W-1:0]    cnt_r;
   logic [CNT_W-1:0]    cnt_nxt_s;
   logic                iss_ok_s;

   assign iss_ok_s = i_iss_en && !(ZERO_REG && (i_iss_addr == ADDR_W'(ZERO_ADDR)));

   // Next pending vector: flush, then write clears, then issue sets (new producer wins).
   always_comb begin
      pend_nxt_s = pend_r;
      if (i_flush) begin
         pend_nxt_s = '0;
      end else begin
         pend_nxt_s = pend_r;
      end
      if (i_wr0_en) begin
         pend_nxt_s[i_wr0_addr] = 1'b0;
      end else begin
         pend_nxt_s = pend_nxt_s;
      end
      if (i_wr1_en) begin
         pend_nxt_s[i_wr1_addr] = 1'b0;
      end else begin
         pend_nxt_s = pend_nxt_s;
      end
      if (iss_ok_s) begin
         pend_nxt_s[i_iss_addr] = 1'b1;
      end else begin
         pend_nxt_s = pend_nxt_s;
      end
   end

   // Population count of the next vector so the count lands on the same edge as the bits.
   always_comb begin
      cnt_nxt_s = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         cnt_nxt_s = cnt_nxt_s + CNT_W'(pend_nxt_s[i]);
      end
   end

   // Pending vector and count registers.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         pend_r <= '0;
         cnt_r  <= '0;
      end else begin
         pend_r <= pend_nxt_s;
         cnt_r  <= cnt_nxt_s;
      end
   end

   assign o_pending  = pend_r;
   assign o_pend_cnt = cnt_r;

endmodule

// File: rtl/reg_file_sb.sv
// Integer register file: N bypassed read ports, two write ports (port 1 wins),
// an unbypassed debug read port and a pending scoreboard for the hazard unit.
module reg_file_sb import reg_file_pkg::*; #(
   parameter int DATA_W   = DATA_W_DEF,
   parameter int NUM_REGS = NUM_REGS_DEF,
   parameter int ADDR_W   = $clog2(NUM_REGS),
   parameter int NUM_RD   = 2,
   parameter bit ZERO_REG = 1'b1
) (
   input  logic                          i_clk,
   input  logic                          i_rst_n,
   input  logic [NUM_RD*ADDR_W-1:0]      i_rd_addr,
   output logic [NUM_RD*DATA_W-1:0]      o_rd_data,
   output logic [NUM_RD-1:0]             o_rd_pending,
   input  logic                          i_wr0_en,
   input  logic [ADDR_W-1:0]             i_wr0_addr,
   input  logic [DATA_W-1:0]             i_wr0_data,
   input  logic                          i_wr1_en,
   input  logic [ADDR_W-1:0]             i_wr1_addr,
   input  logic [DATA_W-1:0]             i_wr1_data,
   input  logic                          i_iss_en,
   input  logic [ADDR_W-1:0]             i_iss_addr,
   input  logic                          i_flush,
   input  logic [ADDR_W-1:0]             i_dbg_addr,
   output logic [DATA_W-1:0]             o_dbg_data,
   output logic [$clog2(NUM_REGS+1)-1:0] o_pend_cnt
);

   localparam logic [ADDR_W-1:0] ZERO_A = ADDR_W'(ZERO_ADDR);

   logic [DATA_W-1:0]   mem_r [NUM_REGS];
   logic [NUM_REGS-1:0] pending_s;
   logic                wr0_ok_s;
   logic                wr1_ok_s;
   logic [ADDR_W-1:0]   rd_addr_s [NUM_RD];

   assign wr0_ok_s = i_wr0_en && !(ZERO_REG && (i_wr0_addr == ZERO_A));
   assign wr1_ok_s = i_wr1_en && !(ZERO_REG && (i_wr1_addr == ZERO_A));

   // Storage array; port 1 is assigned last so it wins a same-address collision.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            mem_r[i] <= '0;
         end
      end else begin
         if (wr0_ok_s) begin
            mem_r[i_wr0_addr] <= i_wr0_data;
         end
         if (wr1_ok_s) begin
            mem_r[i_wr1_addr] <= i_wr1_data;
         end
      end
   end

   reg_scoreboard #(
      .NUM_REGS (NUM_REGS),
      .ADDR_W   (ADDR_W),
      .ZERO_REG (ZERO_REG)
   ) u_scoreboard (
      .i_clk      (i_clk),
      .i_rst_n    (i_rst_n),
      .i_flush    (i_flush),
      .i_wr0_en   (i_wr0_en),
      .i_wr0_addr (i_wr0_addr),
      .i_wr1_en   (i_wr1_en),
      .i_wr1_addr (i_wr1_addr),
      .i_iss_en   (i_iss_en),
      .i_iss_addr (i_iss_addr),
      .o_pending  (pending_s),
      .o_pend_cnt (o_pend_cnt)
   );

   // Bypassed read ports; pending is masked by a same-cycle write so it agrees with the data.
   always_comb begin
      o_rd_data    = '0;
      o_rd_pending = '0;
      for (int k = 0; k < NUM_RD; k++) begin
         rd_addr_s[k] = i_rd_addr[k*ADDR_W +: ADDR_W];
         if (ZERO_REG && (rd_addr_s[k] == ZERO_A)) begin
            o_rd_data[k*DATA_W +: DATA_W] = '0;
            o_rd_pending[k]               = 1'b0;
         end else if (i_wr1_en && (i_wr1_addr == rd_addr_s[k])) begin
            o_rd_data[k*DATA_W +: DATA_W] = i_wr1_data;
            o_rd_pending[k]               = 1'b0;
         end else if (i_wr0_en && (i_wr0_addr == rd_addr_s[k])) begin
            o_rd_data[k*DATA_W +: DATA_W] = i_wr0_data;
            o_rd_pending[k]               = 1'b0;
         end else begin
            o_rd_data[k*DATA_W +: DATA_W] = mem_r[rd_addr_s[k]];
            o_rd_pending[k]               = pending_s[rd_addr_s[k]];
         end
      end
   end

   // Debug port sees committed state only.
   always_comb begin
      if (ZERO_REG && (i_dbg_addr == ZERO_A)) begin
         o_dbg_data = '0;
      end else begin
         o_dbg_data = mem_r[i_dbg_addr];
      end
   end

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed bench: one default instance (32b, 2 ports, zero reg) and one wide
// instance (64b, 4 ports, ordinary reg 0) driven with identical stimulus.
module tb_reg_file_sb;

   logic        clk;
   logic        rst_n;
   logic [19:0] rd_addr;
   logic        wr0_en, wr1_en, iss_en, flush;
   logic [4:0]  wr0_addr, wr1_addr, iss_addr, dbg_addr;
   logic [63:0] wr0_data, wr1_data;

   logic [63:0]  a_rd_data;
   logic [1:0]   a_rd_pend;
   logic [31:0]  a_dbg;
   logic [5:0]   a_cnt;
   logic [255:0] b_rd_data;
   logic [3:0]   b_rd_pend;
   logic [63:0]  b_dbg;
   logic [5:0]   b_cnt;

   int err_cnt = 0;
   int chk_cnt = 0;

   reg_file_sb u_dut_a (
      .i_clk(clk), .i_rst_n(rst_n), .i_rd_addr(rd_addr[9:0]),
      .o_rd_data(a_rd_data), .o_rd_pending(a_rd_pend),
      .i_wr0_en(wr0_en), .i_wr0_addr(wr0_addr), .i_wr0_data(wr0_data[31:0]),
      .i_wr1_en(wr1_en), .i_wr1_addr(wr1_addr), .i_wr1_data(wr1_data[31:0]),
      .i_iss_en(iss_en), .i_iss_addr(iss_addr), .i_flush(flush),
      .i_dbg_addr(dbg_addr), .o_dbg_data(a_dbg), .o_pend_cnt(a_cnt)
   );

   reg_file_sb #(.DATA_W(64), .NUM_RD(4), .ZERO_REG(1'b0)) u_dut_b (
      .i_clk(clk), .i_rst_n(rst_n), .i_rd_addr(rd_addr),
      .o_rd_data(b_rd_data), .o_rd_pending(b_rd_pend),
      .i_wr0_en(wr0_en), .i_wr0_addr(wr0_addr), .i_wr0_data(wr0_data),
      .i_wr1_en(wr1_en), .i_wr1_addr(wr1_addr), .i_wr1_data(wr1_data),
      .i_iss_en(iss_en), .i_iss_addr(iss_addr), .i_flush(flush),
      .i_dbg_addr(dbg_addr), .o_dbg_data(b_dbg), .o_pend_cnt(b_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      chk_cnt++;
      if (act !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   task automatic idle();
      wr0_en = 1'b0; wr1_en = 1'b0; iss_en = 1'b0; flush = 1'b0;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_rd(input int k, input logic [4:0] a);
      rd_addr[k*5 +: 5] = a;
   endtask

   initial begin
      rst_n = 1'b0; rd_addr = '0; dbg_addr = 5'd0;
      wr0_addr = 5'd0; wr1_addr = 5'd0; iss_addr = 5'd0;
      wr0_data = 64'd0; wr1_data = 64'd0;
      idle();
      #12 rst_n = 1'b1;
      step();

      // Some state before a mid-run reset
      wr0_en = 1'b1; wr0_addr = 5'd5; wr0_data = 64'h5555_5555_5555_5555;
      iss_en = 1'b1; iss_addr = 5'd5;
      step();
      idle();
      check("pre_rst_cnt_a", 64'(a_cnt), 64'd1);
      check("pre_rst_cnt_b", 64'(b_cnt), 64'd1);
      #2 rst_n = 1'b0;
      #1;
      for (int k = 0; k < 4; k++) set_rd(k, 5'd5);
      dbg_addr = 5'd5;
      #1;
      check("rst_rd_a", a_rd_data, 64'd0);
      check("rst_rd_b0", b_rd_data[63:0], 64'd0);
      check("rst_rd_b3", b_rd_data[255:192], 64'd0);
      check("rst_pend_a", 64'(a_rd_pend), 64'd0);
      check("rst_pend_b", 64'(b_rd_pend), 64'd0);
      check("rst_cnt_a", 64'(a_cnt), 64'd0);
      check("rst_cnt_b", 64'(b_cnt), 64'd0);
      check("rst_dbg_a", 64'(a_dbg), 64'd0);
      check("rst_dbg_b", b_dbg, 64'd0);
      step();
      rst_n = 1'b1;
      step();

      // Write-to-read bypass, then committed value on debug port
      wr0_en = 1'b1; wr0_addr = 5'd3; wr0_data = 64'h0123_4567_DEAD_BEEF;
      set_rd(0, 5'd3);
      #1;
      check("byp_a", 64'(a_rd_data[31:0]), 64'h0000_0000_DEAD_BEEF);
      check("byp_b", b_rd_data[63:0], 64'h0123_4567_DEAD_BEEF);
      step();
      idle();
      dbg_addr = 5'd3;
      #1;
      check("dbg3_a", 64'(a_dbg), 64'h0000_0000_DEAD_BEEF);
      check("dbg3_b", b_dbg, 64'h0123_4567_DEAD_BEEF);

      // Both write ports to reg 7: port 1 wins
      wr0_en = 1'b1; wr0_addr = 5'd7; wr0_data = 64'h1111_1111_1111_1111;
      wr1_en = 1'b1; wr1_addr = 5'd7; wr1_data = 64'h2222_2222_2222_2222;
      set_rd(1, 5'd7);
      #1;
      check("prio_rd_a", 64'(a_rd_data[63:32]), 64'h0000_0000_2222_2222);
      check("prio_rd_b", b_rd_data[127:64], 64'h2222_2222_2222_2222);
      step();
      idle();
      dbg_addr = 5'd7;
      #1;
      check("prio_dbg_a", 64'(a_dbg), 64'h0000_0000_2222_2222);
      check("prio_dbg_b", b_dbg, 64'h2222_2222_2222_2222);

      // Write and issue to reg 0
      wr0_en = 1'b1; wr0_addr = 5'd0; wr0_data = 64'hAAAA_AAAA_AAAA_AAAA;
      iss_en = 1'b1; iss_addr = 5'd0;
      set_rd(0, 5'd0);
      #1;
      check("z_byp_a", 64'(a_rd_data[31:0]), 64'd0);
      check("z_byp_b", b_rd_data[63:0], 64'hAAAA_AAAA_AAAA_AAAA);
      check("z_byp_pend_a", 64'(a_rd_pend[0]), 64'd0);
      check("z_byp_pend_b", 64'(b_rd_pend[0]), 64'd0);
      step();
      idle();
      #1;
      check("z_rd_a", 64'(a_rd_data[31:0]), 64'd0);
      check("z_rd_b", b_rd_data[63:0], 64'hAAAA_AAAA_AAAA_AAAA);
      check("z_pend_a", 64'(a_rd_pend[0]), 64'd0);
      check("z_pend_b", 64'(b_rd_pend[0]), 64'd1);
      check("z_cnt_a", 64'(a_cnt), 64'd0);
      check("z_cnt_b", 64'(b_cnt), 64'd1);
      flush = 1'b1;
      step();
      idle();
      check("flush_cnt_b", 64'(b_cnt), 64'd0);

      // Scoreboard sequence
      iss_en = 1'b1; iss_addr = 5'd4;
      step();
      iss_addr = 5'd9;
      step();
      idle();
      check("sb2_cnt_a", 64'(a_cnt), 64'd2);
      check("sb2_cnt_b", 64'(b_cnt), 64'd2);
      wr0_en = 1'b1; wr0_addr = 5'd4; wr0_data = 64'h4444_4444_4444_4444;
      iss_en = 1'b1; iss_addr = 5'd4;
      set_rd(0, 5'd4);
      #1;
      check("wi_byp_pend_a", 64'(a_rd_pend[0]), 64'd0);
      step();
      idle();
      #1;
      check("wi_cnt_a", 64'(a_cnt), 64'd2);
      check("wi_cnt_b", 64'(b_cnt), 64'd2);
      check("wi_pend4_a", 64'(a_rd_pend[0]), 64'd1);
      check("wi_pend4_b", 64'(b_rd_pend[0]), 64'd1);
      wr1_en = 1'b1; wr1_addr = 5'd9; wr1_data = 64'h9999_9999_9999_9999;
      set_rd(1, 5'd9);
      set_rd(3, 5'd9);
      #1;
      check("w9_pend_a", 64'(a_rd_pend[1]), 64'd0);
      check("w9_pend_b", 64'(b_rd_pend[3]), 64'd0);
      check("w9_data_a", 64'(a_rd_data[63:32]), 64'h0000_0000_9999_9999);
      step();
      idle();
      #1;
      check("w9_cnt_a", 64'(a_cnt), 64'd1);
      check("w9_cnt_b", 64'(b_cnt), 64'd1);
      check("w9_after_b", 64'(b_rd_pend[3]), 64'd0);

      // Flush together with issue to 12
      flush = 1'b1; iss_en = 1'b1; iss_addr = 5'd12;
      step();
      idle();
      set_rd(0, 5'd12); set_rd(1, 5'd4); set_rd(2, 5'd12); set_rd(3, 5'd7);
      #1;
      check("fi_cnt_a", 64'(a_cnt), 64'd1);
      check("fi_cnt_b", 64'(b_cnt), 64'd1);
      check("fi_pend_a", 64'(a_rd_pend), 64'b01);
      check("fi_pend_b", 64'(b_rd_pend), 64'b0101);
      check("fi_rd7_b", b_rd_data[255:192], 64'h2222_2222_2222_2222);

      $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
      $finish;
   end

endmodule
